ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the sending end of the keyboard link that `ps2_decoder` receives on. It accepts one command byte, such as 0xED (set LEDs) or 0xF4 (enable). It runs the host request-to-send sequence, then shifts the byte, odd parity and stop bit onto the open-drain PS/2 lines under device-generated clocking, and checks the device ACK. It sits in the top level beside `ps2_decoder` and shares the same synchronised `ps2_clk`/`ps2_data` inputs.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_host_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter, the ps2_decoder
// receiver and the keyboard logic.
//   ps2_tx_state_t   : host transmitter FSM states
//   PS2_FRAME_BITS   : start + 8 data + parity + stop
//   PS2_CMD_*        : common host command bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQ,
    TX_SEND,
    TX_ACK,
    TX_WAIT_IDLE,
    TX_DONE,
    TX_FAIL
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_BREAK        = 8'hF0;

endpackage

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Runs the request-to-send sequence (clock inhibit, then clock+data low),
// then shifts 8 data bits (LSB first), odd parity and the stop bit onto the
// open-drain lines under device clocking and checks the device ACK.
// Ports:
//   clk_in, rst_n_in         system clock, synchronous active-low reset
//   ps_clk_in, ps_data_in    synchronised PS/2 lines
//   data_in, valid_in        command byte and send request
//   ready_out                high only when idle; accept = valid_in & ready_out
//   ps_clk_oe_out            1 = pull PS/2 clock low
//   ps_data_oe_out           1 = pull PS/2 data low
//   done_out, err_out        one-cycle completion / failure pulses
// All outputs come straight from flops.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int REQ_CYCLES     = 200,
  parameter int START_TIMEOUT  = 1_500_000,
  parameter int BIT_TIMEOUT    = 200_000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       ps_clk_in,
  input  logic       ps_data_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       ps_clk_oe_out,
  output logic       ps_data_oe_out,
  output logic       done_out,
  output logic       err_out
);

  // CLK_HZ only documents the clock the cycle counts were derived from.
  if (CLK_HZ <= 0) begin : g_clk_hz_invalid
  end

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST  = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_TIMEOUT);
  // Index of the stop bit within the data/parity/stop sequence.
  localparam logic [3:0]       STOP_IDX  = 4'(PS2_FRAME_BITS - 2);

  ps2_tx_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       idx_q, idx_d;
  logic [8:0]       frame_q, frame_d;
  logic             clk_q;
  logic             fall;
  logic             timeout;
  logic             ready_q, ready_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  assign fall    = clk_q & ~ps_clk_in;
  // Saturating increment: a stuck line must never wrap back under a limit.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  // Before the first device edge the long start limit applies.
  assign timeout = (state_q == TX_SEND && idx_q == 4'd0) ? (cnt_q >= START_LIM)
                                                         : (cnt_q >= BIT_LIM);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ready_d   = 1'b0;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      TX_IDLE: begin
        ready_d   = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        if (valid_in && ready_q) begin
          frame_d  = {~^data_in, data_in};
          state_d  = TX_INHIBIT;
          ready_d  = 1'b0;
          clk_oe_d = 1'b1;
        end
      end

      TX_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d   = TX_REQ;
          cnt_d     = '0;
          data_oe_d = 1'b1;
        end
      end

      // Data held low here is the start bit the device clocks in first.
      TX_REQ: begin
        if (cnt_q == REQ_LAST) begin
          state_d  = TX_SEND;
          cnt_d    = '0;
          idx_d    = '0;
          clk_oe_d = 1'b0;
        end
      end

      // A device edge takes priority over a timeout in the same cycle.
      TX_SEND: begin
        if (fall) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q == STOP_IDX) begin
            data_oe_d = 1'b0;
            state_d   = TX_ACK;
          end else begin
            data_oe_d = ~frame_q[idx_q];
          end
        end else if (timeout) begin
          state_d   = TX_FAIL;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
        end
      end

      TX_ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (ps_data_in) begin
            state_d = TX_FAIL;
            err_d   = 1'b1;
          end else begin
            state_d = TX_WAIT_IDLE;
          end
        end else if (timeout) begin
          state_d = TX_FAIL;
          err_d   = 1'b1;
        end
      end

      TX_WAIT_IDLE: begin
        if (ps_clk_in && ps_data_in) begin
          state_d = TX_DONE;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d = TX_FAIL;
          err_d   = 1'b1;
        end
      end

      // DONE and FAIL each hold their pulse for one cycle with ready low.
      TX_DONE: begin
        state_d = TX_IDLE;
        ready_d = 1'b1;
      end

      TX_FAIL: begin
        state_d   = TX_IDLE;
        ready_d   = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end

      default: begin
        state_d   = TX_IDLE;
        ready_d   = 1'b1;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      clk_q     <= 1'b1;
      ready_q   <= 1'b1;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      clk_q     <= ps_clk_in;
      ready_q   <= ready_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Frame payload is only meaningful after an accept, so it carries no reset.
  always_ff @(posedge clk_in) begin
    frame_q <= frame_d;
  end

  assign ready_out      = ready_q;
  assign ps_clk_oe_out  = clk_oe_q;
  assign ps_data_oe_out = data_oe_q;
  assign done_out       = done_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed + randomised bench for ps2_host_tx with a PS/2
// device model driving the shared open-drain lines.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH      = 100;
  localparam int REQ      = 20;
  localparam int START_TO = 3000;
  localparam int BIT_TO   = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       valid;
  logic       ready, clk_oe, data_oe, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps_clk, ps_data;

  // Wired-AND of host and device pull-downs.
  assign ps_clk  = ~(clk_oe | dev_clk_low);
  assign ps_data = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ        (100_000_000),
    .INHIBIT_CYCLES(INH),
    .REQ_CYCLES    (REQ),
    .START_TIMEOUT (START_TO),
    .BIT_TIMEOUT   (BIT_TO)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .ps_clk_in     (ps_clk),
    .ps_data_in    (ps_data),
    .data_in       (data),
    .valid_in      (valid),
    .ready_out     (ready),
    .ps_clk_oe_out (clk_oe),
    .ps_data_oe_out(data_oe),
    .done_out      (done),
    .err_out       (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cycle = 0;
  int last_low = 0;

  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  // Expected frame on the wire, index 0 = start ... index 10 = stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] b, input bit hold);
    chk1("ready_before_accept", ready, 1'b1);
    data  = b;
    valid = 1'b1;
    @(negedge clk);
    if (!hold) begin
      valid = 1'b0;
      data  = 8'($urandom);
    end
    chk1("ready_after_accept", ready, 1'b0);
    chk1("clk_oe_after_accept", clk_oe, 1'b1);
  endtask

  // Starts in the first INHIBIT cycle, ends in the first SEND cycle.
  task automatic measure_req();
    int n;
    n = 0;
    while (clk_oe && !data_oe && n < 4 * INH) begin n++; @(negedge clk); end
    chkn("inhibit_len", n, INH);
    n = 0;
    while (clk_oe && data_oe && n < 4 * REQ) begin n++; @(negedge clk); end
    chkn("req_len", n, REQ);
    chk1("send_clk_released", clk_oe, 1'b0);
    chk1("send_start_bit_held", data_oe, 1'b1);
  endtask

  // Device clocks npulses falling edges with half-period h; pulse 10 is ACK.
  task automatic device(input int npulses, input bit nack, input int h,
                        output logic [10:0] got);
    got = '0;
    cyc(5);
    got[0] = ps_data;
    for (int p = 0; p < npulses; p++) begin
      if (p == 10) dev_data_low = !nack;
      dev_clk_low = 1'b1;
      last_low = cycle;
      cyc(h);
      dev_clk_low = 1'b0;
      cyc(2);
      if (p < 10) got[p + 1] = ps_data;
      cyc(h - 2);
      if (p == 10) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && !err && n < 2000) begin @(negedge clk); n++; end
    chk1("done_pulse", done, 1'b1);
    chk1("err_with_done", err, 1'b0);
    chk1("ready_low_on_done", ready, 1'b0);
    @(negedge clk);
    chk1("ready_after_done", ready, 1'b1);
    chk1("done_one_cycle", done, 1'b0);
  endtask

  task automatic full_frame(input logic [7:0] b, input int h, input bit skip_accept);
    logic [10:0] got;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    if (!skip_accept) accept(b, 1'b0);
    measure_req();
    device(11, 1'b0, h, got);
    wait_done();
    chkn("frame_bits", int'(got), int'(model_frame(b)));
    chkn("frame_odd_parity", ($countones(got[9:1]) % 2), 1);
    cyc(3);
    chkn("done_count", done_cnt - d0, 1);
    chkn("err_count", err_cnt - e0, 0);
  endtask

  initial begin
    logic [10:0] got;
    int n, d0, e0;

    rst_n = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    cyc(3);
    chk1("reset_ready", ready, 1'b1);
    chk1("reset_clk_oe", clk_oe, 1'b0);
    chk1("reset_data_oe", data_oe, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk1("reset_err", err, 1'b0);
    rst_n = 1'b1;
    cyc(2);

    // Enable command, then set-LEDs command (parity 1).
    full_frame(PS2_CMD_ENABLE, 40, 1'b0);
    chkn("f4_expected_frame", int'(model_frame(PS2_CMD_ENABLE)), int'(11'b1_0_1111_0100_0));
    full_frame(PS2_CMD_SET_LEDS, 40, 1'b0);

    // Device never clocks: start timeout.
    e0 = err_cnt;
    accept(8'h3C, 1'b0);
    measure_req();
    n = 0;
    while (!err && n < START_TO + 50) begin @(negedge clk); n++; end
    chkn("start_timeout_cycles", n, START_TO + 1);
    chk1("start_to_clk_oe", clk_oe, 1'b0);
    chk1("start_to_data_oe", data_oe, 1'b0);
    chk1("start_to_done", done, 1'b0);
    @(negedge clk);
    chk1("start_to_ready", ready, 1'b1);
    chk1("start_to_err_one_cycle", err, 1'b0);

    // NACK of 0x00.
    d0 = done_cnt;
    e0 = err_cnt;
    accept(8'h00, 1'b0);
    measure_req();
    device(11, 1'b1, 30, got);
    chk1("nack_parity_bit", got[9], model_frame(8'h00)[9]);
    cyc(3);
    chkn("nack_err_count", err_cnt - e0, 1);
    chkn("nack_done_count", done_cnt - d0, 0);
    chk1("nack_ready", ready, 1'b1);

    // Device stops after bit 4, then 0xFF completes.
    accept(8'hC7, 1'b0);
    measure_req();
    device(5, 1'b0, 30, got);
    chkn("partial_bits", int'(got[5:0]), int'(model_frame(8'hC7)[5:0]));
    n = 0;
    while (!err && n < BIT_TO + 50) begin @(negedge clk); n++; end
    chkn("bit_timeout_cycles", cycle - last_low, BIT_TO + 2);
    @(negedge clk);
    full_frame(8'hFF, 35, 1'b0);

    // Reset during SEND with valid held high while busy.
    e0 = err_cnt;
    accept(8'hA5, 1'b1);
    measure_req();
    device(3, 1'b0, 30, got);
    chk1("busy_valid_ignored_ready", ready, 1'b0);
    chk1("busy_valid_ignored_clk", clk_oe, 1'b0);
    rst_n = 1'b0;
    data  = 8'h5A;
    @(negedge clk);
    rst_n = 1'b1;
    chk1("rst_clk_released", clk_oe, 1'b0);
    chk1("rst_data_released", data_oe, 1'b0);
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_no_err", err, 1'b0);
    @(negedge clk);
    valid = 1'b0;
    chk1("post_rst_accept_ready", ready, 1'b0);
    chk1("post_rst_accept_clk", clk_oe, 1'b1);
    chkn("rst_err_count", err_cnt - e0, 0);
    full_frame(8'h5A, 30, 1'b1);

    // Random bytes and device speeds.
    for (int i = 0; i < 4; i++) begin
      full_frame(8'($urandom), int'($urandom_range(45, 20)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
